// File: rtl/reset_run_sequencer.sv
// Run controller: staggered release of per-channel core resets, then a bounded run
// that ends on a core halt request or when the cycle budget is exhausted.
module reset_run_sequencer #(
   parameter int N_CH        = 2,
   parameter int HOLD_CYC    = 3,
   parameter int STAGGER_CYC = 1,
   parameter int RUN_CYC     = 50,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             abort,
   output logic [N_CH-1:0]  core_rst,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEQ  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Phase value one before the last channel drops; the next cycle is the first RUN cycle.
   localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(HOLD_CYC + (N_CH - 1) * STAGGER_CYC - 1);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((RUN_CYC > 0) ? RUN_CYC - 1 : 0);
   localparam bit               HAS_BUDGET = (RUN_CYC != 0);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] phase_reg, phase_next;
   logic [CNT_W-1:0] cyc_reg, cyc_next;
   logic             timeout_reg, timeout_next;
   logic [N_CH-1:0]  core_rst_reg, core_rst_next;
   logic [N_CH-1:0]  seq_rst;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         phase_reg    <= '0;
         cyc_reg      <= '0;
         timeout_reg  <= 1'b0;
         core_rst_reg <= '1;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         cyc_reg      <= cyc_next;
         timeout_reg  <= timeout_next;
         core_rst_reg <= core_rst_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      cyc_next     = cyc_reg;
      timeout_next = timeout_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_SEQ;
               phase_next = '0;
            end
         end
         S_SEQ: begin
            if (phase_reg == LAST_M1) begin
               state_next = S_RUN;
               phase_next = phase_reg + 1'b1;
               cyc_next   = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_RUN: begin
            // Halt wins over the terminal count; the counter freezes on exit.
            if (halt) begin
               state_next   = S_DONE;
               timeout_next = 1'b0;
            end else if (HAS_BUDGET && (cyc_reg == RUN_LAST)) begin
               state_next   = S_DONE;
               timeout_next = 1'b1;
            end else if (cyc_reg != '1) begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               state_next   = S_SEQ;
               phase_next   = '0;
               cyc_next     = '0;
               timeout_next = 1'b0;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (abort) begin
         state_next   = S_IDLE;
         phase_next   = '0;
         cyc_next     = '0;
         timeout_next = 1'b0;
      end
   end

   // Channel gi stays in reset while the upcoming phase is below its release point.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_rel
         localparam logic [CNT_W-1:0] REL_T = CNT_W'(HOLD_CYC + gi * STAGGER_CYC);
         assign seq_rst[gi] = (phase_next < REL_T);
      end
   endgenerate

   always_comb begin
      core_rst_next = '0;
      case (state_next)
         S_IDLE:  core_rst_next = '1;
         S_SEQ:   core_rst_next = seq_rst;
         default: core_rst_next = '0;
      endcase
   end

   assign core_rst = core_rst_reg;
   assign running  = (state_reg == S_RUN);
   assign done     = (state_reg == S_DONE);
   assign timeout  = timeout_reg;
   assign cyc_cnt  = cyc_reg;
   assign state    = state_reg;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Scoreboard bench: dut_a uses defaults, dut_b a 4-channel stagger, dut_c a
// single channel with the timeout disabled and a narrow saturating counter.
module tb_reset_run_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_a, start_a, halt_a, abort_a;
   logic [1:0]  core_rst_a;
   logic        running_a, done_a, timeout_a;
   logic [15:0] cyc_cnt_a;
   logic [1:0]  state_a;

   logic        reset_b, start_b, halt_b, abort_b;
   logic [3:0]  core_rst_b;
   logic        running_b, done_b, timeout_b;
   logic [7:0]  cyc_cnt_b;
   logic [1:0]  state_b;

   logic [0:0]  core_rst_c;
   logic        running_c, done_c, timeout_c;
   logic [3:0]  cyc_cnt_c;
   logic [1:0]  state_c;

   reset_run_sequencer dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .halt(halt_a), .abort(abort_a),
      .core_rst(core_rst_a), .running(running_a), .done(done_a), .timeout(timeout_a),
      .cyc_cnt(cyc_cnt_a), .state(state_a)
   );

   reset_run_sequencer #(.N_CH(4), .HOLD_CYC(1), .STAGGER_CYC(2), .RUN_CYC(5), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .halt(halt_b), .abort(abort_b),
      .core_rst(core_rst_b), .running(running_b), .done(done_b), .timeout(timeout_b),
      .cyc_cnt(cyc_cnt_b), .state(state_b)
   );

   reset_run_sequencer #(.N_CH(1), .HOLD_CYC(2), .STAGGER_CYC(0), .RUN_CYC(0), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset_b), .start(start_b), .halt(halt_b), .abort(abort_b),
      .core_rst(core_rst_c), .running(running_c), .done(done_c), .timeout(timeout_c),
      .cyc_cnt(cyc_cnt_c), .state(state_c)
   );

   int checks = 0;
   int errors = 0;

   logic [22:0] q_a[$];
   logic [16:0] q_b[$];
   logic [9:0]  q_c[$];

   wire [22:0] obs_a = {state_a, core_rst_a, running_a, done_a, timeout_a, cyc_cnt_a};
   wire [16:0] obs_b = {state_b, core_rst_b, running_b, done_b, timeout_b, cyc_cnt_b};
   wire [9:0]  obs_c = {state_c, core_rst_c, running_c, done_c, timeout_c, cyc_cnt_c};

   function automatic logic [22:0] ea(input logic [1:0] st, input logic [1:0] cr,
                                      input logic tmo, input int cc);
      return {st, cr, st == 2'd2, st == 2'd3, tmo, 16'(cc)};
   endfunction

   // Default parameters, start sampled at the edge of step 0, no halt.
   function automatic logic [22:0] seq_exp_a(input int k);
      if (k < 3)  return ea(2'd1, 2'b11, 1'b0, 0);
      if (k == 3) return ea(2'd1, 2'b10, 1'b0, 0);
      if (k < 54) return ea(2'd2, 2'b00, 1'b0, k - 4);
      return ea(2'd3, 2'b00, 1'b1, 49);
   endfunction

   function automatic logic [16:0] exp_b(input int k);
      logic [3:0] cr;
      if (k < 7) begin
         cr = (k == 0) ? 4'b1111 : (k < 3) ? 4'b1110 : (k < 5) ? 4'b1100 : 4'b1000;
         return {2'd1, cr, 1'b0, 1'b0, 1'b0, 8'd0};
      end
      if (k < 12) return {2'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 8'(k - 7)};
      return {2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd4};
   endfunction

   function automatic logic [9:0] exp_c(input int k);
      if (k < 2)  return {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
      if (k < 23) return {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, (k - 2 > 15) ? 4'd15 : 4'(k - 2)};
      return {2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15};
   endfunction

   task automatic test_reset();
      logic [22:0] e;
      for (int k = 0; k < 4; k++) begin
         reset_a = (k >= 2);
         reset_b = (k >= 2);
         start_a = (k < 2);
         q_a.push_back(ea(2'd0, 2'b11, 1'b0, 0));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      start_a = 1'b0;
      $display("test_reset: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_timeout();
      logic [22:0] e;
      for (int k = 0; k < 57; k++) begin
         start_a = (k == 0);
         q_a.push_back(seq_exp_a(k));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL timeout k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      start_a = 1'b0;
      $display("test_timeout: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_halt();
      logic [22:0] e;
      for (int k = 0; k < 15; k++) begin
         start_a = (k == 0);
         halt_a  = (k >= 1 && k <= 3) || (k == 12);
         q_a.push_back((k < 12) ? seq_exp_a(k) : ea(2'd3, 2'b00, 1'b0, 7));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL halt k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      halt_a = 1'b0;
      $display("test_halt: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_halt_terminal();
      logic [22:0] e;
      for (int k = 0; k < 56; k++) begin
         start_a = (k == 0);
         halt_a  = (k == 54);
         q_a.push_back((k < 54) ? seq_exp_a(k) : ea(2'd3, 2'b00, 1'b0, 49));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL halt_terminal k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      halt_a = 1'b0;
      $display("test_halt_terminal: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_start_held();
      logic [22:0] e;
      for (int k = 0; k < 57; k++) begin
         start_a = (k < 56);
         abort_a = (k == 56);
         if (k <= 54)      q_a.push_back(seq_exp_a(k));
         else if (k == 55) q_a.push_back(seq_exp_a(0));
         else              q_a.push_back(ea(2'd0, 2'b11, 1'b0, 0));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL start_held k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      start_a = 1'b0;
      abort_a = 1'b0;
      $display("test_start_held: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_abort();
      logic [22:0] e;
      for (int k = 0; k < 83; k++) begin
         start_a = (k == 0) || (k == 25) || (k == 26);
         abort_a = (k == 25);
         if (k < 25)       q_a.push_back(seq_exp_a(k));
         else if (k == 25) q_a.push_back(ea(2'd0, 2'b11, 1'b0, 0));
         else              q_a.push_back(seq_exp_a(k - 26));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL abort k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      start_a = 1'b0;
      abort_a = 1'b0;
      $display("test_abort: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_run();
      logic [22:0] e;
      for (int k = 0; k < 4; k++) begin
         start_a = (k == 0);
         reset_a = (k != 2);
         q_a.push_back((k < 2) ? seq_exp_a(k) : ea(2'd0, 2'b11, 1'b0, 0));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset_mid_seq k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      for (int k = 0; k < 9; k++) begin
         start_a = (k == 0);
         if (k == 6) begin
            reset_a = 1'b0;
            #3;
            reset_a = 1'b1;
         end
         q_a.push_back(seq_exp_a(k));
         @(posedge clk); #1;
         e = q_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset_glitch k=%0d got=%h exp=%h", k, obs_a, e);
         end
      end
      start_a = 1'b0;
      $display("test_reset_mid_run: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_variants();
      logic [16:0] eb;
      logic [9:0]  ec;
      for (int k = 0; k < 26; k++) begin
         start_b = (k == 0);
         halt_b  = (k == 23);
         q_b.push_back(exp_b(k));
         q_c.push_back(exp_c(k));
         @(posedge clk); #1;
         eb = q_b.pop_front();
         ec = q_c.pop_front();
         checks++;
         if (obs_b !== eb) begin
            errors++;
            $display("FAIL stagger k=%0d got=%h exp=%h", k, obs_b, eb);
         end
         checks++;
         if (obs_c !== ec) begin
            errors++;
            $display("FAIL saturate k=%0d got=%h exp=%h", k, obs_c, ec);
         end
      end
      halt_b = 1'b0;
      $display("test_variants: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      reset_a = 1'b0; start_a = 1'b0; halt_a = 1'b0; abort_a = 1'b0;
      reset_b = 1'b0; start_b = 1'b0; halt_b = 1'b0; abort_b = 1'b0;
      test_reset();
      test_timeout();
      test_halt();
      test_halt_terminal();
      test_start_held();
      test_abort();
      test_reset_mid_run();
      test_variants();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
